// File: rtl/checksum_sched.sv
// Round-robin shared 16-bit ones-complement checksum engine: one requester
// streams a job of words, the sum is folded, complemented and handed off.
module checksum_sched #(
  parameter int NUM_REQ   = 2,
  parameter int IDW       = 1,
  parameter int MAX_WORDS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  output logic [NUM_REQ-1:0]      grant,
  input  logic [16*NUM_REQ-1:0]   data_in,
  input  logic [NUM_REQ-1:0]      valid_in,
  input  logic [NUM_REQ-1:0]      last_in,
  output logic [NUM_REQ-1:0]      ready_out,
  output logic [15:0]             sum_out,
  output logic [IDW-1:0]          sum_id,
  output logic [15:0]             sum_len,
  output logic                    sum_err,
  output logic                    sum_valid,
  input  logic                    sum_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_FOLD1 = 3'd2,
    S_FOLD2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [IDW-1:0]       gid_q, gid_d;
  logic [IDW-1:0]       rr_q, rr_d;
  logic [31:0]          acc_q, acc_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [15:0]          sum_out_q, sum_out_d;
  logic [IDW-1:0]       sum_id_q, sum_id_d;
  logic [15:0]          sum_len_q, sum_len_d;
  logic                 sum_err_q, sum_err_d;
  logic                 sum_valid_q, sum_valid_d;

  logic [IDW:0]         pick_s;
  logic [15:0]          data_g_s;
  logic                 beat_s;
  logic                 last_s;
  logic [15:0]          cnt_inc_s;
  logic [31:0]          fold_s;

  // One end-around-carry step; two steps always leave the sum within 16 bits.
  function automatic logic [31:0] fold(input logic [31:0] a);
    return {16'h0000, a[31:16]} + {16'h0000, a[15:0]};
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      v[j] = (IDW'(j) == idx);
    end
    return v;
  endfunction

  // {found, index}: lowest request at or above ptr, else lowest request overall.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [IDW-1:0] ptr);
    logic [IDW:0] hi;
    logic [IDW:0] lo;
    hi = '0;
    lo = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      hi = (r[j] && (IDW'(j) >= ptr)) ? {1'b1, IDW'(j)} : hi;
      lo = r[j] ? {1'b1, IDW'(j)} : lo;
    end
    return hi[IDW] ? hi : lo;
  endfunction

  // Next-state and datapath computation for the arbiter/accumulator FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ready_d     = ready_q;
    gid_d       = gid_q;
    rr_d        = rr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    sum_out_d   = sum_out_q;
    sum_id_d    = sum_id_q;
    sum_len_d   = sum_len_q;
    sum_err_d   = sum_err_q;
    sum_valid_d = sum_valid_q;

    pick_s    = rr_pick(req, rr_q);
    data_g_s  = 16'h0000;
    for (int j = 0; j < NUM_REQ; j++) begin
      data_g_s = data_g_s | (data_in[16*j +: 16] & {16{grant_q[j]}});
    end
    // ready_q is only ever set for the owner, so foreign beats never count.
    beat_s    = |(valid_in & ready_q);
    last_s    = |(last_in & grant_q);
    cnt_inc_s = cnt_q + 16'd1;
    fold_s    = fold(acc_q);

    case (state_q)
      S_IDLE: begin
        if (pick_s[IDW]) begin
          state_d = S_ACCUM;
          gid_d   = pick_s[IDW-1:0];
          grant_d = onehot(pick_s[IDW-1:0]);
          ready_d = onehot(pick_s[IDW-1:0]);
          acc_d   = 32'h0000_0000;
          cnt_d   = 16'h0000;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (beat_s) begin
          acc_d = acc_q + {16'h0000, data_g_s};
          cnt_d = cnt_inc_s;
          if (last_s || (cnt_inc_s == MAX_W)) begin
            state_d = S_FOLD1;
            ready_d = '0;
            err_d   = !last_s;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_FOLD1: begin
        acc_d   = fold_s;
        state_d = S_FOLD2;
      end
      S_FOLD2: begin
        acc_d       = fold_s;
        sum_out_d   = ~fold_s[15:0];
        sum_id_d    = gid_q;
        sum_len_d   = cnt_q;
        sum_err_d   = err_q;
        sum_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (sum_ack) begin
          state_d     = S_IDLE;
          grant_d     = '0;
          sum_valid_d = 1'b0;
          rr_d        = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + IDW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        grant_d     = '0;
        ready_d     = '0;
        sum_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ready_q     <= '0;
      gid_q       <= '0;
      rr_q        <= '0;
      acc_q       <= 32'h0000_0000;
      cnt_q       <= 16'h0000;
      err_q       <= 1'b0;
      sum_out_q   <= 16'h0000;
      sum_id_q    <= '0;
      sum_len_q   <= 16'h0000;
      sum_err_q   <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      gid_q       <= gid_d;
      rr_q        <= rr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      sum_out_q   <= sum_out_d;
      sum_id_q    <= sum_id_d;
      sum_len_q   <= sum_len_d;
      sum_err_q   <= sum_err_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign grant     = grant_q;
  assign ready_out = ready_q;
  assign sum_out   = sum_out_q;
  assign sum_id    = sum_id_q;
  assign sum_len   = sum_len_q;
  assign sum_err   = sum_err_q;
  assign sum_valid = sum_valid_q;

endmodule
